// File: rtl/pci_pkg.sv
// PCI command encodings, target state encoding and DEVSEL# speed codes.
// Shared by the target phase controller and its command filter.
package pci_pkg;

    localparam logic [3:0] CMD_IO_RD  = 4'h2;
    localparam logic [3:0] CMD_IO_WR  = 4'h3;
    localparam logic [3:0] CMD_MEM_RD = 4'h6;
    localparam logic [3:0] CMD_MEM_WR = 4'h7;
    localparam logic [3:0] CMD_CFG_RD = 4'hA;
    localparam logic [3:0] CMD_CFG_WR = 4'hB;
    localparam logic [3:0] CMD_MRM    = 4'hC;
    localparam logic [3:0] CMD_MRL    = 4'hE;
    localparam logic [3:0] CMD_MWI    = 4'hF;

    localparam int DEVSEL_FAST = 0;
    localparam int DEVSEL_MED  = 1;
    localparam int DEVSEL_SLOW = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_DATA,
        ST_TURN
    } tgt_state_t;

    // Even command codes are the read flavours of each read/write pair.
    function automatic logic cmd_is_read(input logic [3:0] c);
        return ~c[0];
    endfunction

endpackage

// File: rtl/pci_cmd_filter.sv
// Address-phase claim check: external hit qualified by the accepted-command mask.
// Latency: combinational. Backpressure: none.
// Also classifies the command as read or write.
module pci_cmd_filter
    import pci_pkg::*;
#(
    parameter logic [15:0] ACCEPT_MASK = 16'hCCCC
) (
    input  logic [3:0] cmd_in,
    input  logic       hit,
    output logic       claim,
    output logic       is_rd
);

    assign claim = hit & ACCEPT_MASK[cmd_in];
    assign is_rd = cmd_is_read(cmd_in);

endmodule

// File: rtl/pci_target_phase_ctrl.sv
// PCI target bus-cycle controller: claim, DEVSEL# decode delay, burst data phases, disconnect.
// Latency: DEVSEL# max(DEVSEL_DLY,1)+1 clocks after the address phase; xfer/be_n/phase_cnt one clock after the phase.
// Backpressure: TRDY# follows local_ready; optional retry timeout under PCI_TGT_RETRY_EN.
module pci_target_phase_ctrl
    import pci_pkg::*;
#(
    parameter int          CNT_W       = 4,
    parameter int          MAX_BURST   = 8,
    parameter int          DEVSEL_DLY  = 1,
    parameter logic [15:0] ACCEPT_MASK = 16'hCCCC,
    parameter int          RETRY_CLKS  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_n,
    input  logic             irdy_n,
    input  logic [3:0]       cbe_n,
    input  logic             hit,
    input  logic             local_ready,
    output logic             devsel_n,
    output logic             trdy_n,
    output logic             stop_n,
    output logic             t_oe,
    output logic [3:0]       cmd,
    output logic             is_read,
    output logic [3:0]       be_n,
    output logic             xfer,
    output logic [CNT_W-1:0] phase_cnt
);

    localparam int               DLY_CLKS   = (DEVSEL_DLY == DEVSEL_FAST) ? 1 : DEVSEL_DLY;
    localparam logic [1:0]       DLY_LAST   = 2'(DLY_CLKS - 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] BURST_END  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    tgt_state_t state_q, state_d;
    logic       bus_idle_q, first_q, stop_q;
    logic [1:0] dly_q;
    logic       claim, claim_rd, addr_phase, transfer;
    logic       trdy_ok, stop_req, burst_done, retry_now;

    pci_cmd_filter #(.ACCEPT_MASK(ACCEPT_MASK)) u_filter (
        .cmd_in (cbe_n),
        .hit    (hit),
        .claim  (claim),
        .is_rd  (claim_rd)
    );

`ifdef PCI_TGT_RETRY_EN
    localparam int            RW         = $clog2(RETRY_CLKS + 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_CLKS - 1);
    logic [RW-1:0] wait_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_q <= '0;
        else if (state_q != ST_DATA)
            wait_q <= '0;
        else if (wait_q != RETRY_LAST)
            wait_q <= wait_q + 1'b1;
    end

    // Initial-latency timeout only applies before the first completed phase.
    assign retry_now = (state_q == ST_DATA) && (phase_cnt == '0) && (wait_q == RETRY_LAST);
`else
    // No initial-latency timer: the target waits on local_ready indefinitely.
    assign retry_now = (RETRY_CLKS < 0);
`endif

    always_comb begin
        addr_phase = !frame_n && bus_idle_q;
        burst_done = (phase_cnt >= BURST_END);
        // Reads hold TRDY# off for the first DATA clock (AD turnaround).
        trdy_ok    = local_ready && !(is_read && first_q) && !burst_done && !retry_now;
        stop_req   = stop_q || retry_now || ((phase_cnt == BURST_LAST) && !frame_n);

        state_d  = state_q;
        devsel_n = 1'b1;
        trdy_n   = 1'b1;
        stop_n   = 1'b1;
        t_oe     = (state_q != ST_IDLE);
        transfer = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (addr_phase && claim)
                    state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (dly_q == DLY_LAST)
                    state_d = ST_DATA;
            end
            ST_DATA: begin
                devsel_n = 1'b0;
                trdy_n   = !trdy_ok;
                stop_n   = !stop_req;
                transfer = !irdy_n && trdy_ok;
                if (frame_n && (transfer || stop_req))
                    state_d = ST_TURN;
            end
            ST_TURN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bus_idle_q <= 1'b1;
            dly_q      <= 2'd0;
            first_q    <= 1'b0;
            stop_q     <= 1'b0;
            cmd        <= 4'h0;
            is_read    <= 1'b0;
            be_n       <= 4'hF;
            xfer       <= 1'b0;
            phase_cnt  <= '0;
        end else begin
            state_q    <= state_d;
            bus_idle_q <= frame_n && irdy_n;
            dly_q      <= (state_q == ST_DECODE) ? dly_q + 2'd1 : 2'd0;
            first_q    <= (state_q == ST_DECODE) && (state_d == ST_DATA);
            stop_q     <= (state_q == ST_DATA) && !stop_n;
            xfer       <= transfer;
            if (state_q == ST_IDLE && addr_phase && claim) begin
                cmd       <= cbe_n;
                is_read   <= claim_rd;
                phase_cnt <= '0;
            end else if (transfer) begin
                be_n <= cbe_n;
                if (phase_cnt != CNT_MAX)
                    phase_cnt <= phase_cnt + 1'b1;
            end
        end
    end

endmodule
